// File: rtl/qpsk_demap_pack.sv
// QPSK hard-decision demapper, MSB-first symbol packer and FWFT word FIFO with valid/ready output.
// Optional low-confidence symbol counter is enabled by defining QPSK_DEMAP_CONF_EN.
module qpsk_demap_pack #(
    parameter int DW            = 11,
    parameter int SYMS_PER_WORD = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int THRESH        = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       valid_x,
    input  logic signed [DW-1:0]       xr,
    input  logic signed [DW-1:0]       xi,
    input  logic                       flush_i,
    output logic                       valid_o,
    output logic [2*SYMS_PER_WORD-1:0] data_o,
    output logic                       last_o,
    input  logic                       ready_i,
    output logic                       overflow_o
`ifdef QPSK_DEMAP_CONF_EN
    ,
    input  logic                       cnt_clr_i,
    output logic [15:0]                lowconf_cnt_o
`endif
);

    localparam int WW = 2 * SYMS_PER_WORD;
    localparam int CW = $clog2(SYMS_PER_WORD + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Stage 1: registered sign decisions, flush kept aligned with its symbol
    logic [1:0] dec_reg;
    logic       dec_valid_reg;
    logic       flush_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dec_reg       <= '0;
            dec_valid_reg <= 1'b0;
            flush_reg     <= 1'b0;
        end else begin
            dec_valid_reg <= valid_x;
            flush_reg     <= flush_i;
            if (valid_x)
                dec_reg <= {xr[DW-1], xi[DW-1]};
        end
    end

    // Stage 2: packer
    logic [CW-1:0] cnt_reg;
    logic [WW-1:0] shift_reg;
    logic [WW-1:0] word_reg;
    logic          word_last_reg;
    logic          word_valid_reg;

    logic [WW+1:0] sh_full;
    logic [WW-1:0] sh_next;
    logic [CW-1:0] n_next;
    logic          emit;
    logic [WW-1:0] word_next;

    always_comb begin
        sh_full   = {shift_reg, dec_reg};
        sh_next   = dec_valid_reg ? sh_full[WW-1:0] : shift_reg;
        n_next    = cnt_reg + CW'(dec_valid_reg);
        emit      = (n_next == CW'(SYMS_PER_WORD)) || (flush_reg && (n_next != '0));
        word_next = '0;
        // Left-justify: a word of k symbols is shifted up so the first symbol lands in the MSBs
        for (int k = 1; k <= SYMS_PER_WORD; k++) begin
            if (n_next == CW'(k))
                word_next = sh_next << (2 * (SYMS_PER_WORD - k));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_reg        <= '0;
            shift_reg      <= '0;
            word_reg       <= '0;
            word_last_reg  <= 1'b0;
            word_valid_reg <= 1'b0;
        end else if (emit) begin
            cnt_reg        <= '0;
            shift_reg      <= '0;
            word_reg       <= word_next;
            word_last_reg  <= flush_reg;
            word_valid_reg <= 1'b1;
        end else begin
            cnt_reg        <= n_next;
            shift_reg      <= sh_next;
            word_valid_reg <= 1'b0;
        end
    end

    // Stage 3: FIFO input register, then write into the word FIFO
    logic [WW:0] fifo_in_reg;
    logic        fifo_in_valid_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fifo_in_reg       <= '0;
            fifo_in_valid_reg <= 1'b0;
        end else begin
            fifo_in_valid_reg <= word_valid_reg;
            if (word_valid_reg)
                fifo_in_reg <= {word_last_reg, word_reg};
        end
    end

    logic [WW:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;

    logic full;
    logic pop;
    logic do_write;
    logic drop;
    logic [WW:0] head;

    always_comb begin
        full     = (count_reg == (AW+1)'(FIFO_DEPTH));
        pop      = valid_o && ready_i;
        // A pop on the same edge frees the slot, so a full FIFO still accepts
        do_write = fifo_in_valid_reg && (!full || pop);
        drop     = fifo_in_valid_reg && full && !pop;
    end

    always_ff @(posedge CLK) begin
        if (do_write)
            mem[wr_ptr_reg] <= fifo_in_reg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_write, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop)
                overflow_reg <= 1'b1;
        end
    end

    // Head is gated so the outputs read zero whenever the FIFO is empty
    always_comb begin
        valid_o    = (count_reg != '0);
        head       = mem[rd_ptr_reg];
        data_o     = valid_o ? head[WW-1:0] : '0;
        last_o     = valid_o && head[WW];
        overflow_o = overflow_reg;
    end

`ifdef QPSK_DEMAP_CONF_EN
    // Magnitudes need DW+1 bits so that -2^(DW-1) stays positive
    logic [DW:0]  abs_r;
    logic [DW:0]  abs_i;
    logic [DW:0]  abs_min;
    logic         lowconf;
    logic [15:0]  lowconf_cnt_reg;

    always_comb begin
        abs_r   = xr[DW-1] ? -{xr[DW-1], xr} : {xr[DW-1], xr};
        abs_i   = xi[DW-1] ? -{xi[DW-1], xi} : {xi[DW-1], xi};
        abs_min = (abs_r < abs_i) ? abs_r : abs_i;
        lowconf = valid_x && (abs_min < (DW+1)'(THRESH));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            lowconf_cnt_reg <= '0;
        else if (cnt_clr_i)
            lowconf_cnt_reg <= '0;
        else if (lowconf && (lowconf_cnt_reg != 16'hFFFF))
            lowconf_cnt_reg <= lowconf_cnt_reg + 16'd1;
    end

    assign lowconf_cnt_o = lowconf_cnt_reg;
`endif

endmodule

// File: tb/tb_qpsk_demap_pack.sv
// Scoreboard testbench for qpsk_demap_pack: directed vectors, random traffic, overflow and reset cases.
// Low-confidence counter checks are included when QPSK_DEMAP_CONF_EN is defined.
module tb_qpsk_demap_pack;

    localparam int DW    = 11;
    localparam int SPW   = 4;
    localparam int DEPTH = 8;
    localparam int WW    = 2 * SPW;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 valid_x = 1'b0;
    logic signed [DW-1:0] xr = '0;
    logic signed [DW-1:0] xi = '0;
    logic                 flush_i = 1'b0;
    logic                 ready_i = 1'b1;
    logic                 valid_o;
    logic [WW-1:0]        data_o;
    logic                 last_o;
    logic                 overflow_o;
`ifdef QPSK_DEMAP_CONF_EN
    logic                 cnt_clr_i = 1'b0;
    logic [15:0]          lowconf_cnt_o;
`endif

    qpsk_demap_pack #(.DW(DW), .SYMS_PER_WORD(SPW), .FIFO_DEPTH(DEPTH), .THRESH(4)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .valid_x       (valid_x),
        .xr            (xr),
        .xi            (xi),
        .flush_i       (flush_i),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .last_o        (last_o),
        .ready_i       (ready_i),
        .overflow_o    (overflow_o)
`ifdef QPSK_DEMAP_CONF_EN
        ,
        .cnt_clr_i     (cnt_clr_i),
        .lowconf_cnt_o (lowconf_cnt_o)
`endif
    );

    always #5 CLK = ~CLK;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [WW:0]   sb_q[$];
    logic [WW-1:0] m_acc = '0;
    int            m_n = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Drive one cycle of inputs; sampled by the next rising edge
    task automatic drive(input logic v, input int r, input int i, input logic fl);
        valid_x = v;
        xr      = DW'(r);
        xi      = DW'(i);
        flush_i = fl;
        @(posedge CLK);
        #1;
        valid_x = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic expect_word(input logic [WW:0] w);
        sb_q.push_back(w);
    endtask

    // Reference packer: decisions appended, flushed words left-justified
    task automatic model(input logic v, input int r, input int i, input logic fl);
        logic [WW-1:0] w;
        if (v) begin
            m_acc = {m_acc[WW-3:0], (r < 0), (i < 0)};
            m_n++;
        end
        if (m_n == SPW || (fl && m_n > 0)) begin
            w = m_acc << (2 * (SPW - m_n));
            // With the sink stalled, words beyond the FIFO capacity are lost
            if (sb_q.size() < DEPTH || ready_i)
                sb_q.push_back({fl, w});
            m_acc = '0;
            m_n   = 0;
        end
    endtask

    task automatic rand_sym(input logic v, input logic fl);
        int r;
        int i;
        r = int'($urandom_range(0, 2047)) - 1024;
        i = int'($urandom_range(0, 2047)) - 1024;
        model(v, r, i, fl);
        drive(v, r, i, fl);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            if (!valid_o && sb_q.size() == 0) begin
                @(posedge CLK);
                #1;
                return;
            end
            @(negedge CLK);
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RST && valid_o && ready_i) begin
            if (sb_q.size() == 0)
                check("word_unexpected", 32'({last_o, data_o}), 32'h200);
            else
                check("word", 32'({last_o, data_o}), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);

        // Basic quadrant mapping and output latency
        expect_word({1'b0, 8'h1B});
        drive(1, 8, 8, 0);
        drive(1, 8, -8, 0);
        drive(1, -8, 8, 0);
        drive(1, -8, -8, 0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("lat_e2_valid", 32'(valid_o), 32'd0);
        @(negedge CLK);
        check("lat_e3_valid", 32'(valid_o), 32'd1);
        check("lat_e3_data", 32'(data_o), 32'h1B);
        check("lat_e3_last", 32'(last_o), 32'd0);
        wait_idle();

        // Zero and extreme values
        expect_word({1'b0, 8'h26});
        drive(1, 0, 0, 0);
        drive(1, -1, 0, 0);
        drive(1, 0, -1, 0);
        drive(1, -1024, 1023, 0);
        wait_idle();

        // Flush alone on a partial word, then a clean full word
        expect_word({1'b1, 8'hD0});
        expect_word({1'b0, 8'h32});
        drive(1, -8, -8, 0);
        drive(1, 8, -8, 0);
        drive(0, 0, 0, 1);
        drive(1, 8, 8, 0);
        drive(1, -8, -8, 0);
        drive(1, 8, 8, 0);
        drive(1, -8, 8, 0);
        // Flush with the final symbol marks a full word last; idle flush does nothing
        expect_word({1'b1, 8'h57});
        drive(1, 8, -8, 0);
        drive(1, 8, -8, 0);
        drive(1, 8, -8, 0);
        drive(1, -8, -8, 1);
        drive(0, 0, 0, 1);
        wait_idle();

`ifdef QPSK_DEMAP_CONF_EN
        check("conf_init", 32'(lowconf_cnt_o), 32'd0);
        expect_word({1'b0, 8'h1C});
        drive(1, 3, 100, 0);
        drive(1, 100, -8, 0);
        drive(1, -1024, -1024, 0);
        drive(1, 0, 5, 0);
        check("conf_count", 32'(lowconf_cnt_o), 32'd2);
        cnt_clr_i = 1'b1;
        expect_word({1'b0, 8'hAD});
        drive(1, -2, 2, 0);
        cnt_clr_i = 1'b0;
        check("conf_clr_wins", 32'(lowconf_cnt_o), 32'd0);
        drive(1, -1024, 1, 0);
        drive(1, -3, -5, 0);
        drive(1, 4, -4, 0);
        check("conf_recount", 32'(lowconf_cnt_o), 32'd2);
        wait_idle();
`endif

        // Random traffic with gaps, random flushes and sink stalls
        for (int k = 0; k < 200; k++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            rand_sym($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end
        ready_i = 1'b1;
        rand_sym(0, 1);
        wait_idle();

        // Overflow: nine words into an eight-deep FIFO with the sink stalled
        ready_i = 1'b0;
        for (int k = 0; k < 36; k++)
            rand_sym(1, 0);
        repeat (6) @(posedge CLK);
        #1;
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_full_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        wait_idle();
        check("ovf_sticky", 32'(overflow_o), 32'd1);

        // Asynchronous reset mid-clock with words held in the FIFO
        ready_i = 1'b0;
        for (int k = 0; k < 8; k++)
            rand_sym(1, 0);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_valid", 32'(valid_o), 32'd0);
        check("async_rst_data", 32'(data_o), 32'd0);
        check("async_rst_ovf", 32'(overflow_o), 32'd0);
`ifdef QPSK_DEMAP_CONF_EN
        check("async_rst_conf", 32'(lowconf_cnt_o), 32'd0);
`endif
        sb_q.delete();
        m_acc = '0;
        m_n   = 0;
        @(posedge CLK);
        #1;
        RST     = 1'b0;
        ready_i = 1'b1;

        // Reset after two symbols of a word discards the partial word
        drive(1, -8, -8, 0);
        drive(1, -8, -8, 0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        expect_word({1'b0, 8'h27});
        drive(1, 8, 8, 0);
        drive(1, -8, 8, 0);
        drive(1, 8, -8, 0);
        drive(1, -8, -8, 0);
        wait_idle();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
